// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit order, hex glyph table and
// the forward (hex -> pattern) encoder used by the display driver side.
package seg_pkg;

    // Bit positions on the active-low common-anode segment bus.
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments dark: the digit shows nothing.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Result of looking a captured pattern up in the glyph table.
    typedef struct packed {
        logic [3:0] hex;
        logic       hit;
        logic       blank;
    } seg_dec_t;

    // Forward encoder: hex value to active-low g..a pattern.
    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        logic [6:0] pat;
        case (value)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0011000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b0100111;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_pattern_dec.sv
// Reverse glyph lookup: segment pattern to hex value, with hit/blank flags.
module seg_pattern_dec
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec
);

    // Compare against every glyph the forward encoder can produce.
    always_comb begin
        dec = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == seg_encode(4'(i))) begin
                dec.hex = 4'(i);
                dec.hit = 1'b1;
            end
        end
        dec.blank = (pattern == SEG_BLANK);
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Recovers per-digit hex values from a multiplexed seven-segment scan by
// waiting for each anode/segment combination to settle before capturing it.
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int SETTLE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NDIG-1:0]     an,
    input  logic [7:0]          led,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     dp_out,
    output logic [NDIG-1:0]     digit_ok,
    output logic                frame_valid,
    output logic                err_pattern,
    output logic                err_anode
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Counter value seen on the edge just before the capturing edge.
    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    logic [1:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NDIG-1:0]     an_q, an_d;
    logic [7:0]          led_q, led_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [NDIG-1:0]     dp_q, dp_d;
    logic [NDIG-1:0]     ok_q, ok_d;
    logic [NDIG-1:0]     seen_q, seen_d;
    logic                frame_valid_q, frame_valid_d;
    logic                err_pattern_q, err_pattern_d;
    logic                err_anode_q, err_anode_d;

    logic [NDIG-1:0]     an_low, an_low_q;
    logic                cur_multi, cur_single, prev_multi;
    logic                changed;
    logic                capture;
    logic [NDIG-1:0]     dig_cap;
    seg_dec_t            dec;

    // Anode classification: active-low enables turned into active-high.
    assign an_low     = ~an;
    assign an_low_q   = ~an_q;
    assign cur_multi  = |(an_low & (an_low - NDIG'(1)));
    assign cur_single = (|an_low) && !cur_multi;
    assign prev_multi = |(an_low_q & (an_low_q - NDIG'(1)));
    assign changed    = (an != an_q) || (led != led_q);

    // Capture works from the registered sample, which equals the pins when unchanged.
    seg_pattern_dec u_dec (
        .pattern (led_q[SEG_G:SEG_A]),
        .dec     (dec)
    );

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_cap
        assign dig_cap[gi] = capture & an_low_q[gi];
    end

    // Settle FSM: any change restarts the window; a full quiet window captures.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        err_anode_d = 1'b0;
        an_d        = an;
        led_d       = led;
        if (changed) begin
            cnt_d       = 8'd0;
            state_d     = cur_single ? ST_SETTLE : ST_IDLE;
            err_anode_d = cur_multi && !prev_multi;
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                capture = 1'b1;
                state_d = ST_HOLD;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Digit registers and frame accounting driven by the capture strobe.
    always_comb begin
        bcd_d         = bcd_q;
        dp_d          = dp_q;
        ok_d          = ok_q;
        err_pattern_d = capture && !dec.hit && !dec.blank;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_cap[k]) begin
                if (dec.hit) begin
                    bcd_d[4*k +: 4] = dec.hex;
                    dp_d[k]         = ~led_q[SEG_DP];
                    ok_d[k]         = 1'b1;
                end else if (dec.blank) begin
                    dp_d[k] = ~led_q[SEG_DP];
                    ok_d[k] = 1'b0;
                end else begin
                    ok_d[k] = 1'b0;
                end
            end
        end
        // A completed frame is reported one edge later; that edge opens the next frame.
        frame_valid_d = &seen_q;
        seen_d        = (&seen_q) ? dig_cap : (seen_q | dig_cap);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            an_q          <= '1;
            led_q         <= '1;
            bcd_q         <= '0;
            dp_q          <= '0;
            ok_q          <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            err_pattern_q <= 1'b0;
            err_anode_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            an_q          <= an_d;
            led_q         <= led_d;
            bcd_q         <= bcd_d;
            dp_q          <= dp_d;
            ok_q          <= ok_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            err_pattern_q <= err_pattern_d;
            err_anode_q   <= err_anode_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign dp_out      = dp_q;
    assign digit_ok    = ok_q;
    assign frame_valid = frame_valid_q;
    assign err_pattern = err_pattern_q;
    assign err_anode   = err_anode_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: directed scenarios plus a randomized scan
// checked against a segment-level behavioural model.
module tb_seg_scan_reader;

    localparam int NDIG   = 4;
    localparam int SETTLE = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NDIG-1:0]     an  = '1;
    logic [7:0]          led = '1;
    logic [4*NDIG-1:0]   bcd_out;
    logic [NDIG-1:0]     dp_out;
    logic [NDIG-1:0]     digit_ok;
    logic                frame_valid;
    logic                err_pattern;
    logic                err_anode;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int ep_cnt   = 0;
    int ea_cnt   = 0;

    logic [6:0] tb_hex [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_reader #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .led         (led),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (frame_valid === 1'b1) fv_cnt++;
        if (err_pattern === 1'b1) ep_cnt++;
        if (err_anode === 1'b1)   ea_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges; called and returns at a falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        an  = '1;
        led = '1;
        tick(2);
        rst = 1'b0;
        fv_cnt = 0;
        ep_cnt = 0;
        ea_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        an  = '1;
        led = '1;
        tick(2);
        n_checks++;
        if ({bcd_out, dp_out, digit_ok, frame_valid, err_pattern, err_anode} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required 0",
                     {bcd_out, dp_out, digit_ok, frame_valid, err_pattern, err_anode});
        end
        rst = 1'b0;
        tick(3);
        n_checks++;
        if ({bcd_out, dp_out, digit_ok, frame_valid, err_pattern, err_anode} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h required 0",
                     {bcd_out, dp_out, digit_ok, frame_valid, err_pattern, err_anode});
        end
        $display("test_reset done");
    endtask

    task automatic test_capture_timing();
        apply_reset();
        an  = 4'b1110;
        led = 8'b0010_0100;
        for (int e = 1; e <= SETTLE + 1; e++) begin
            tick(1);
            n_checks++;
            if (e <= SETTLE) begin
                if ({digit_ok[0], dp_out[0]} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL capture_early edge %0d: got ok=%b dp=%b required 0 0",
                             e, digit_ok[0], dp_out[0]);
                end
            end else begin
                if ({bcd_out[3:0], dp_out[0], digit_ok[0]} !== {4'h2, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL capture_edge9: got bcd=%h dp=%b ok=%b required 2 1 1",
                             bcd_out[3:0], dp_out[0], digit_ok[0]);
                end
            end
        end
        $display("test_capture_timing done");
    endtask

    task automatic test_restart();
        apply_reset();
        an  = 4'b1110;
        led = {1'b1, tb_hex[3]};
        tick(5);
        led = {1'b1, tb_hex[5]};
        for (int e = 1; e <= SETTLE + 1; e++) begin
            tick(1);
            n_checks++;
            if (e <= SETTLE) begin
                if (digit_ok[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL restart_early edge %0d: got ok=%b required 0", e, digit_ok[0]);
                end
            end else begin
                if ({bcd_out[3:0], digit_ok[0]} !== {4'h5, 1'b1}) begin
                    n_fail++;
                    $display("FAIL restart_capture: got bcd=%h ok=%b required 5 1",
                             bcd_out[3:0], digit_ok[0]);
                end
            end
        end
        $display("test_restart done");
    endtask

    task automatic test_scan();
        logic [NDIG-1:0] sel;
        apply_reset();
        for (int d = 0; d < NDIG; d++) begin
            sel = ~(NDIG'(1) << d);
            an  = sel;
            led = {1'b1, tb_hex[d + 1]};
            for (int e = 1; e <= 10; e++) begin
                tick(1);
                n_checks++;
                if (frame_valid !== ((d == NDIG - 1) && (e == 10))) begin
                    n_fail++;
                    $display("FAIL scan_frame digit %0d edge %0d: got %b", d, e, frame_valid);
                end
            end
        end
        n_checks++;
        if (fv_cnt !== 1) begin
            n_fail++;
            $display("FAIL scan_frame_count: got %0d required 1", fv_cnt);
        end
        n_checks++;
        if ({bcd_out, digit_ok, dp_out} !== {16'h4321, 4'hF, 4'h0}) begin
            n_fail++;
            $display("FAIL scan_values: got bcd=%h ok=%b dp=%b required 4321 1111 0000",
                     bcd_out, digit_ok, dp_out);
        end
        $display("test_scan done");
    endtask

    // Runs right after test_scan so previously captured values must survive.
    task automatic test_bad_pattern();
        an  = 4'b1110;
        led = 8'b1101_0101;
        for (int e = 1; e <= SETTLE + 1; e++) begin
            tick(1);
            n_checks++;
            if (err_pattern !== (e == SETTLE + 1)) begin
                n_fail++;
                $display("FAIL bad_pattern_pulse edge %0d: got %b", e, err_pattern);
            end
        end
        n_checks++;
        if ({bcd_out, digit_ok, dp_out} !== {16'h4321, 4'hE, 4'h0}) begin
            n_fail++;
            $display("FAIL bad_pattern_state: got bcd=%h ok=%b dp=%b required 4321 1110 0000",
                     bcd_out, digit_ok, dp_out);
        end
        $display("test_bad_pattern done");
    endtask

    task automatic test_multi_anode();
        apply_reset();
        an  = 4'b1100;
        led = {1'b1, tb_hex[0]};
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            n_checks++;
            if (err_anode !== (e == 1)) begin
                n_fail++;
                $display("FAIL multi_anode_pulse edge %0d: got %b", e, err_anode);
            end
        end
        n_checks++;
        if ({ea_cnt, bcd_out, digit_ok} !== {32'd1, 16'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL multi_anode_nocap: got pulses=%0d bcd=%h ok=%b required 1 0 0",
                     ea_cnt, bcd_out, digit_ok);
        end
        $display("test_multi_anode done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        an  = 4'b1101;
        led = {1'b1, tb_hex[7]};
        tick(10);
        n_checks++;
        if ({bcd_out[7:4], digit_ok} !== {4'h7, 4'b0010}) begin
            n_fail++;
            $display("FAIL reset_mid_precap: got bcd=%h ok=%b required 7 0010",
                     bcd_out[7:4], digit_ok);
        end
        an  = 4'b1110;
        led = {1'b1, tb_hex[9]};
        tick(4);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bcd_out, dp_out, digit_ok, frame_valid, err_pattern, err_anode} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h required 0",
                     {bcd_out, dp_out, digit_ok, frame_valid, err_pattern, err_anode});
        end
        @(negedge clk);
        tick(1);
        rst = 1'b0;
        for (int e = 1; e <= SETTLE + 1; e++) begin
            tick(1);
            n_checks++;
            if (e <= SETTLE) begin
                if (digit_ok !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL reset_mid_early edge %0d: got ok=%b required 0000", e, digit_ok);
                end
            end else begin
                if ({bcd_out, digit_ok} !== {16'h0009, 4'b0001}) begin
                    n_fail++;
                    $display("FAIL reset_mid_capture: got bcd=%h ok=%b required 0009 0001",
                             bcd_out, digit_ok);
                end
            end
        end
        $display("test_reset_mid done");
    endtask

    // Segment-level model: a segment held for h edges is captured iff it
    // drives exactly one digit and h reaches SETTLE+1.
    task automatic test_random();
        logic [3:0]      m_bcd [NDIG];
        logic            m_dp  [NDIG];
        logic            m_ok  [NDIG];
        logic            m_seen[NDIG];
        int              m_fv = 0;
        int              m_ep = 0;
        int              m_ea = 0;
        logic [NDIG-1:0] prev_an  = '1;
        logic [7:0]      prev_led = '1;
        logic [NDIG-1:0] new_an;
        logic [7:0]      new_led;
        logic [4*NDIG-1:0] exp_bcd;
        logic [NDIG-1:0] exp_dp, exp_ok;
        int              h, r, k, b2, idx, lows;
        logic            all_seen;

        apply_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_bcd[i] = 4'h0; m_dp[i] = 1'b0; m_ok[i] = 1'b0; m_seen[i] = 1'b0;
        end
        for (int s = 0; s < 60; s++) begin
            do begin
                r = int'($urandom_range(0, 9));
                if (r == 0) new_an = '1;
                else if (r == 1) begin
                    k  = int'($urandom_range(0, NDIG - 1));
                    b2 = (k + 1 + int'($urandom_range(0, NDIG - 2))) % NDIG;
                    new_an = '1;
                    new_an[k]  = 1'b0;
                    new_an[b2] = 1'b0;
                end else begin
                    new_an = '1;
                    new_an[$urandom_range(0, NDIG - 1)] = 1'b0;
                end
                r = int'($urandom_range(0, 9));
                if (r <= 5)      new_led = {1'($urandom_range(0, 1)), tb_hex[$urandom_range(0, 15)]};
                else if (r == 6) new_led = {1'($urandom_range(0, 1)), 7'b1111111};
                else             new_led = 8'($urandom_range(0, 255));
            end while (new_an == prev_an && new_led == prev_led);

            h   = int'($urandom_range(1, SETTLE + 6));
            an  = new_an;
            led = new_led;
            tick(h);

            lows = $countones(~new_an);
            if (lows > 1 && $countones(~prev_an) <= 1) m_ea++;
            if (lows == 1 && h >= SETTLE + 1) begin
                k = 0;
                for (int i = 0; i < NDIG; i++) if (!new_an[i]) k = i;
                idx = -1;
                for (int v = 0; v < 16; v++) if (tb_hex[v] == new_led[6:0]) idx = v;
                if (idx >= 0) begin
                    m_bcd[k] = 4'(idx);
                    m_dp[k]  = ~new_led[7];
                    m_ok[k]  = 1'b1;
                end else if (new_led[6:0] == 7'b1111111) begin
                    m_dp[k] = ~new_led[7];
                    m_ok[k] = 1'b0;
                end else begin
                    m_ok[k] = 1'b0;
                    m_ep++;
                end
                m_seen[k] = 1'b1;
                all_seen = 1'b1;
                for (int i = 0; i < NDIG; i++) all_seen &= m_seen[i];
                if (all_seen) begin
                    m_fv++;
                    for (int i = 0; i < NDIG; i++) m_seen[i] = 1'b0;
                end
            end
            prev_an  = new_an;
            prev_led = new_led;

            for (int i = 0; i < NDIG; i++) begin
                exp_bcd[4*i +: 4] = m_bcd[i];
                exp_dp[i]         = m_dp[i];
                exp_ok[i]         = m_ok[i];
            end
            n_checks++;
            if ({bcd_out, dp_out, digit_ok} !== {exp_bcd, exp_dp, exp_ok}) begin
                n_fail++;
                $display("FAIL random_seg %0d an=%b led=%b h=%0d: got bcd=%h dp=%b ok=%b required bcd=%h dp=%b ok=%b",
                         s, new_an, new_led, h, bcd_out, dp_out, digit_ok, exp_bcd, exp_dp, exp_ok);
            end else begin
                $display("seg %0d an=%b led=%b h=%0d bcd=%h ok=%b", s, new_an, new_led, h, bcd_out, digit_ok);
            end
        end
        an  = '1;
        led = '1;
        tick(3);
        n_checks++;
        if ({fv_cnt, ep_cnt, ea_cnt} !== {m_fv, m_ep, m_ea}) begin
            n_fail++;
            $display("FAIL random_pulses: got frame=%0d pat=%0d anode=%0d required %0d %0d %0d",
                     fv_cnt, ep_cnt, ea_cnt, m_fv, m_ep, m_ea);
        end
        $display("test_random done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_capture_timing();
        test_restart();
        test_scan();
        test_bad_pattern();
        test_multi_anode();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
